// File: rtl/div_n_jk_driver_pkg.sv
// Shared types and constants for the divide-by-N J-K driver.
// Holds the FSM states, the J-K drive codes and the minimum legal divisor.
package div_n_jk_driver_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        JK_HOLD  = 2'b00,
        JK_RESET = 2'b01,
        JK_SET   = 2'b10
    } jk_code_e;

    localparam int unsigned MIN_DIV = 2;

    // Picks the J-K code that moves a flip-flop from cur to nxt; never yields 11.
    function automatic jk_code_e jk_encode(input logic cur, input logic nxt);
        jk_code_e code;
        case ({cur, nxt})
            2'b01:   code = JK_SET;
            2'b10:   code = JK_RESET;
            default: code = JK_HOLD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/div_n_jk_driver_counter.sv
// Modulo-n period counter: counts 0..n-1 while running, wraps, holds 0 otherwise.
// Exposes its next value so the parent can register outputs aligned to the count.
module div_n_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic [WIDTH-1:0] cnt_d_o,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             last_s;

    // Next count: advance inside a period, back to 0 on wrap, idle or reset.
    always_comb begin
        last_s = run_i && (cnt_q == (n_i - WIDTH'(1)));
        cnt_d  = '0;
        if (rst_i) begin
            cnt_d = '0;
        end else if (run_i && !last_s) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
    assign last_o  = last_s;

endmodule

// File: rtl/div_n_jk_driver.sv
// Divide-by-N waveform generator with divisor load handshake and J-K drive.
// j/k look one cycle ahead so an external J-K flip-flop reproduces div_out exactly.
module div_n_jk_driver
    import div_n_jk_driver_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int RST_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             j,
    output logic             k,
    output logic             div_out,
    output logic             tick,
    output logic             running
);

    localparam logic [WIDTH-1:0] RST_N = WIDTH'(RST_DIV);
    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_DIV);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cur_n_q, cur_n_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             div_out_q, div_out_d;
    logic             tick_q, tick_d;
    logic             run_q, run_d;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] cnt_d_s;
    logic             last_s;
    logic [WIDTH:0]   half_s;
    jk_code_e         jk_s;
    logic [1:0]       jk_bits_s;

    div_n_counter #(.WIDTH(WIDTH)) u_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .run_i   (state_q == ST_RUN),
        .n_i     (cur_n_q),
        .cnt_o   (cnt_s),
        .cnt_d_o (cnt_d_s),
        .last_o  (last_s)
    );

    // FSM, divisor handshake and next values of the registered outputs.
    // In RUN the ack is raised on the cycle before the period-ending edge so it
    // is visible on the last cycle; the new divisor lands on that edge.
    always_comb begin
        state_d = state_q;
        cur_n_d = cur_n_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        if (rst) begin
            state_d = ST_IDLE;
            cur_n_d = RST_N;
            pend_d  = RST_N;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (div_load && !ack_q) begin
                        ack_d = 1'b1;
                        if (div_val < MIN_N) begin
                            err_d = 1'b1;
                        end else begin
                            cur_n_d = div_val;
                        end
                    end else begin
                        ack_d = 1'b0;
                    end
                    state_d = en ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (div_load && !ack_q && (cnt_s == (cur_n_q - WIDTH'(2)))) begin
                        ack_d = 1'b1;
                        if (div_val < MIN_N) begin
                            err_d = 1'b1;
                        end else begin
                            pend_d = div_val;
                        end
                    end else begin
                        ack_d = 1'b0;
                    end
                    if (last_s) begin
                        if (ack_q && !err_q) begin
                            cur_n_d = pend_q;
                        end else begin
                            cur_n_d = cur_n_q;
                        end
                        state_d = en ? ST_RUN : ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        half_s    = ({1'b0, cur_n_d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        run_d     = (state_d == ST_RUN);
        div_out_d = run_d && ({1'b0, cnt_d_s} < half_s);
        tick_d    = run_d && (cnt_d_s == (cur_n_d - WIDTH'(1)));
        jk_s      = jk_encode(div_out_q, div_out_d);
        jk_bits_s = jk_s;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_n_q   <= RST_N;
            pend_q    <= RST_N;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_n_q   <= cur_n_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
            run_q     <= run_d;
        end
    end

    assign div_ack = ack_q;
    assign div_err = err_q;
    assign div_out = div_out_q;
    assign tick    = tick_q;
    assign running = run_q;
    assign j       = jk_bits_s[1];
    assign k       = jk_bits_s[0];

endmodule

// File: tb/tb_div_n_jk_driver.sv
// Randomized bench for div_n_jk_driver against a period-level reference model,
// plus a model J-K flip-flop that must follow div_out every cycle.
module tb_div_n_jk_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] div_val;
    logic       div_load;
    logic       div_ack, div_err, j, k, div_out, tick, running;

    always #5 clk = ~clk;

    div_n_jk_driver #(.WIDTH(4), .RST_DIV(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .j        (j),
        .k        (k),
        .div_out  (div_out),
        .tick     (tick),
        .running  (running)
    );

    // Reference: whether a period is running, position inside it, divisor,
    // and the handshake flags visible this cycle.
    typedef struct {
        bit run;
        int pos;
        int n;
        bit ack;
        bit err;
        int pend;
    } mdl_t;

    mdl_t m;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;
    bit   prev_ack = 1'b0;
    bit   jkq = 1'b0;
    bit   jj, kk;
    bit   s_rst, s_en, s_load;
    logic [3:0] s_val;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_out(mdl_t s);
        return s.run && (s.pos < (s.n + 1) / 2);
    endfunction

    function automatic mdl_t m_step(mdl_t c, bit r, bit e, bit ld, int v);
        mdl_t s = c;
        if (r) begin
            s.run = 1'b0; s.pos = 0; s.n = 3; s.ack = 1'b0; s.err = 1'b0; s.pend = 3;
            return s;
        end
        s.ack = 1'b0;
        s.err = 1'b0;
        if (!c.run) begin
            if (ld && !c.ack) begin
                s.ack = 1'b1;
                s.err = (v < 2);
                if (v >= 2) s.n = v;
            end
            s.run = e;
            s.pos = 0;
        end else begin
            if (ld && !c.ack && c.pos == c.n - 2) begin
                s.ack = 1'b1;
                s.err = (v < 2);
                if (v >= 2) s.pend = v;
            end
            if (c.pos == c.n - 1) begin
                s.pos = 0;
                if (c.ack && !c.err) s.n = c.pend;
                if (!e) s.run = 1'b0;
            end else begin
                s.pos = c.pos + 1;
            end
        end
        return s;
    endfunction

    task automatic cyc();
        mdl_t nxt;
        bit   ej, ek;
        @(negedge clk);
        if (chk_on) begin
            check("div_out", div_out, m_out(m));
            check("tick", tick, (m.run && m.pos == m.n - 1) ? 1 : 0);
            check("running", running, m.run);
            check("div_ack", div_ack, m.ack);
            check("div_err", div_err, m.ack ? m.err : 1'b0);
            check("jk_track", jkq, div_out);
        end
        if (prev_ack) s_load = 1'b0;
        prev_ack = m.ack;
        rst      = s_rst;
        en       = s_en;
        div_load = s_load;
        div_val  = s_val;
        #1;
        nxt = m_step(m, s_rst, s_en, s_load, int'(s_val));
        ej  = m_out(nxt) && !m_out(m);
        ek  = !m_out(nxt) && m_out(m);
        if (chk_on) begin
            check("j", j, ej);
            check("k", k, ek);
            check("jk_not_11", j & k, 0);
        end
        jj = j;
        kk = k;
        @(posedge clk);
        m = nxt;
        if (s_rst) jkq = 1'b0;
        else if (jj) jkq = 1'b1;
        else if (kk) jkq = 1'b0;
        else jkq = jkq;
    endtask

    task automatic wait_pos(input int p, input int n_req);
        int guard = 0;
        while (!(m.run && m.pos == p && (n_req == 0 || m.n == n_req)) && guard < 40) begin
            cyc();
            guard++;
        end
        if (guard >= 40) check("wait_pos_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (m.run && guard < 40) begin
            cyc();
            guard++;
        end
        if (guard >= 40) check("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        m = '{run: 1'b0, pos: 0, n: 3, ack: 1'b0, err: 1'b0, pend: 3};
        s_rst = 1'b1; s_en = 1'b0; s_load = 1'b0; s_val = 4'd0;
        cyc();
        chk_on = 1'b1;
        cyc();

        // Free-running divide by 3 from reset.
        s_rst = 1'b0; s_en = 1'b1;
        repeat (9) cyc();

        // Load 5 raised at cnt=0: ack on the last cycle, next period 1,1,1,0,0.
        wait_pos(0, 3);
        s_load = 1'b1; s_val = 4'd5;
        repeat (12) cyc();

        // Rejected divisor in IDLE, then resume.
        s_en = 1'b0;
        wait_idle();
        cyc();
        s_load = 1'b1; s_val = 4'd1;
        repeat (4) cyc();
        s_load = 1'b1; s_val = 4'd3;
        repeat (3) cyc();
        s_en = 1'b1;
        repeat (6) cyc();

        // Switch to N=4, then drop en at cnt=0: period completes.
        s_load = 1'b1; s_val = 4'd4;
        wait_pos(0, 4);
        s_en = 1'b0;
        repeat (7) cyc();

        // Reset mid-period with a request pending.
        s_en = 1'b1;
        repeat (4) cyc();
        wait_pos(1, 0);
        s_load = 1'b1; s_val = 4'd7; s_rst = 1'b1;
        cyc();
        s_rst = 1'b0; s_load = 1'b0;
        repeat (8) cyc();

        // Random en, loads (including illegal divisors) and occasional reset.
        repeat (200) begin
            s_en  = ($urandom_range(0, 7) != 0);
            s_rst = ($urandom_range(0, 49) == 0);
            if (!s_load && $urandom_range(0, 3) == 0) begin
                s_load = 1'b1;
                s_val  = 4'($urandom_range(0, 15));
            end
            cyc();
        end
        s_rst = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
